// File: rtl/cacheline_burst_responder_if.sv
// ---------------------------------------------------------------------------
// cacheline_burst_responder_if
//
// Purpose: groups the two buses handled by the cache-line burst responder.
//   - Cache side (pmem_*): a line-fill or line-writeback request with a
//     256-bit line and a one-cycle completion strobe.
//   - Memory side (burst_*): a 4-beat, 64-bit burst with a per-beat
//     response/accept strobe.
//
// Signals:
//   pmem_read      cache line-fill request
//   pmem_write     cache line-writeback request
//   pmem_address   32-bit line address from the cache
//   pmem_wdata     256-bit writeback line
//   pmem_rdata     256-bit assembled fill line (to cache)
//   pmem_resp      one-cycle completion strobe (to cache)
//   burst_read     memory read burst request
//   burst_write    memory write burst request
//   burst_address  32-bit burst base address
//   burst_wdata    64-bit current write beat
//   burst_rdata    64-bit current read beat (from memory)
//   burst_resp     memory accepts/returns one beat this cycle
//
// Modports:
//   slave  - the responder's view (takes cache requests, drives the burst bus)
//   master - the environment's view (cache + memory model)
// ---------------------------------------------------------------------------
interface cacheline_burst_responder_if;
  logic         pmem_read;
  logic         pmem_write;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;

  logic         burst_read;
  logic         burst_write;
  logic [31:0]  burst_address;
  logic [63:0]  burst_wdata;
  logic [63:0]  burst_rdata;
  logic         burst_resp;

  modport slave (
    input  pmem_read,
    input  pmem_write,
    input  pmem_address,
    input  pmem_wdata,
    output pmem_rdata,
    output pmem_resp,
    output burst_read,
    output burst_write,
    output burst_address,
    output burst_wdata,
    input  burst_rdata,
    input  burst_resp
  );

  modport master (
    output pmem_read,
    output pmem_write,
    output pmem_address,
    output pmem_wdata,
    input  pmem_rdata,
    input  pmem_resp,
    input  burst_read,
    input  burst_write,
    input  burst_address,
    input  burst_wdata,
    output burst_rdata,
    output burst_resp
  );
endinterface

// File: rtl/cacheline_burst_responder.sv
// ---------------------------------------------------------------------------
// cacheline_burst_responder
//
// Purpose: converts a 256-bit cache line request into a 4-beat x 64-bit
// memory burst. A fill (pmem_read) collects four read beats into pmem_rdata;
// a writeback (pmem_write) streams the latched line out as four write beats.
// Completion is signalled by a single-cycle pmem_resp, after which the block
// returns to IDLE.
//
// Ports:
//   clk   - single clock, all state changes on the rising edge
//   rst   - asynchronous, active-high reset
//   bus   - cacheline_burst_responder_if.slave (cache + memory buses)
//
// Parameters:
//   BEATS - 64-bit beats per line; the line is 256 bits, so this is 4.
//
// All outputs are decoded from registered state only; nothing on the input
// side of the bus reaches an output combinationally.
// ---------------------------------------------------------------------------
module cacheline_burst_responder #(
  parameter int BEATS = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  cacheline_burst_responder_if.slave  bus
);

  localparam int BEAT_W = 64;
  localparam int CNT_W  = $clog2(BEATS);
  // Byte offset within a 32-byte line; these address bits are forced to 0.
  localparam int OFFS_W = $clog2(BEATS * BEAT_W / 8);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t                         state_q, state_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic [31:0]                    addr_q, addr_d;
  logic [BEATS-1:0][BEAT_W-1:0]   wline_q, wline_d;
  logic [BEATS-1:0][BEAT_W-1:0]   rdata_q, rdata_d;

  logic                           beat_accept;
  logic [BEATS-1:0]               rbeat_we;
  logic [31:0]                    line_addr;

  // The low address bits only select a byte inside the line and are dropped.
  logic addr_offset_unused;
  assign addr_offset_unused = ^bus.pmem_address[OFFS_W-1:0];

  assign line_addr = {bus.pmem_address[31:OFFS_W], {OFFS_W{1'b0}}};

  // A beat only counts while a burst is actually in flight; stray responses
  // in IDLE or DONE are ignored.
  assign beat_accept = bus.burst_resp &&
                       ((state_q == ST_READ) || (state_q == ST_WRITE));

  // -------------------------------------------------------------------------
  // Read-beat capture: each 64-bit slot of the fill line has its own write
  // enable, selected by the beat counter. Slots not being written hold, so
  // the previous fill line survives writebacks untouched.
  // -------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < BEATS; gi++) begin : g_rbeat
      assign rbeat_we[gi] = (state_q == ST_READ) && bus.burst_resp &&
                            (cnt_q == CNT_W'(gi));
      assign rdata_d[gi]  = rbeat_we[gi] ? bus.burst_rdata : rdata_q[gi];
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Next-state and request latching.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wline_d = wline_q;

    unique case (state_q)
      ST_IDLE: begin
        // Writeback has priority over fill when both are requested.
        if (bus.pmem_write) begin
          state_d = ST_WRITE;
          addr_d  = line_addr;
          wline_d = bus.pmem_wdata;
          cnt_d   = '0;
        end else if (bus.pmem_read) begin
          state_d = ST_READ;
          addr_d  = line_addr;
          cnt_d   = '0;
        end
      end

      ST_READ,
      ST_WRITE: begin
        if (beat_accept) begin
          // The counter is exactly log2(BEATS) wide, so it wraps to 0
          // on the last beat without any explicit clear.
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_BEAT) begin
            state_d = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State registers. Reset is asynchronous so a burst in progress is dropped
  // immediately, without waiting for a clock edge.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wline_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wline_q <= wline_d;
      rdata_q <= rdata_d;
    end
  end

  // -------------------------------------------------------------------------
  // Output decode (registered state only).
  // -------------------------------------------------------------------------
  assign bus.burst_read    = (state_q == ST_READ);
  assign bus.burst_write   = (state_q == ST_WRITE);
  assign bus.burst_address = ((state_q == ST_READ) || (state_q == ST_WRITE)) ?
                             addr_q : '0;
  assign bus.burst_wdata   = (state_q == ST_WRITE) ? wline_q[cnt_q] : '0;
  assign bus.pmem_resp     = (state_q == ST_DONE);
  assign bus.pmem_rdata    = rdata_q;

endmodule

// File: tb/tb_cacheline_burst_responder.sv
// ---------------------------------------------------------------------------
// tb_cacheline_burst_responder
//
// Directed scenarios followed by a randomized phase. A transaction-level
// model (request kind, beats accepted so far, held fill line) predicts every
// output each cycle; a few hand-computed literals pin the model.
// Inputs change on the falling edge; outputs are compared on the falling edge.
// ---------------------------------------------------------------------------
module tb_cacheline_burst_responder;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  cacheline_burst_responder_if bus ();

  cacheline_burst_responder #(.BEATS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  localparam logic [255:0] A_LINE = {64'hA3A3_A3A3_0000_0003, 64'hA2A2_A2A2_0000_0002,
                                     64'hA1A1_A1A1_0000_0001, 64'hA0A0_A0A0_0000_0000};
  localparam logic [255:0] L_LINE = {64'hDDDD_0000_1111_4444, 64'hCCCC_0000_1111_3333,
                                     64'hBBBB_0000_1111_2222, 64'hAAAA_0000_1111_1111};
  localparam logic [255:0] B_LINE = {64'hB3B3_0000_0000_B003, 64'hB2B2_0000_0000_B002,
                                     64'hB1B1_0000_0000_B001, 64'hB0B0_0000_0000_B000};
  localparam logic [255:0] C_LINE = {64'h0C30_0C30_0C30_0C30, 64'h0C20_0C20_0C20_0C20,
                                     64'h0C10_0C10_0C10_0C10, 64'h0C00_0C00_0C00_0C00};
  localparam logic [255:0] E_LINE = {64'hE3E3_E3E3_E3E3_E3E3, 64'hE2E2_E2E2_E2E2_E2E2,
                                     64'hE1E1_E1E1_E1E1_E1E1, 64'hE0E0_E0E0_E0E0_E0E0};
  localparam logic [255:0] F_LINE = {64'hF3F3_0F0F_F3F3_0F0F, 64'hF2F2_0F0F_F2F2_0F0F,
                                     64'hF1F1_0F0F_F1F1_0F0F, 64'hF0F0_0F0F_F0F0_0F0F};

  int checks = 0;
  int errors = 0;

  // Behavioural model: which request is being served (0 none, 1 fill,
  // 2 writeback), how many beats have been taken, whether the completion
  // strobe is due this cycle, and the fill line the cache should see.
  int           m_kind;
  bit           m_done;
  int           m_beats;
  logic [31:0]  m_addr;
  logic [255:0] m_line;
  logic [255:0] m_rdata;

  // Per-transaction observations.
  logic [31:0]  t_first_addr;
  logic         t_first_rd;
  logic         t_first_wr;
  bit           t_saw_read;
  logic [63:0]  wq[$];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_kind  = 0;
    m_done  = 1'b0;
    m_beats = 0;
    m_addr  = '0;
    m_line  = '0;
    m_rdata = '0;
  endtask

  // Advances the model by one rising edge using the inputs presented there.
  task automatic model_step();
    if (m_done) begin
      m_done = 1'b0;
    end else if (m_kind != 0) begin
      if (bus.burst_resp) begin
        if (m_kind == 1) m_rdata[64*m_beats +: 64] = bus.burst_rdata;
        m_beats++;
        if (m_beats == 4) begin
          m_kind  = 0;
          m_beats = 0;
          m_done  = 1'b1;
        end
      end
    end else if (bus.pmem_write) begin
      m_kind  = 2;
      m_addr  = {bus.pmem_address[31:5], 5'b0};
      m_line  = bus.pmem_wdata;
      m_beats = 0;
    end else if (bus.pmem_read) begin
      m_kind  = 1;
      m_addr  = {bus.pmem_address[31:5], 5'b0};
      m_beats = 0;
    end
  endtask

  task automatic check_cycle();
    logic [63:0] e_wd;
    logic [31:0] e_addr;
    e_wd   = (m_kind == 2) ? m_line[64*m_beats +: 64] : 64'd0;
    e_addr = (m_kind != 0) ? m_addr : 32'd0;
    chk("burst_read",    bus.burst_read,    m_kind == 1);
    chk("burst_write",   bus.burst_write,   m_kind == 2);
    chk("burst_address", bus.burst_address, e_addr);
    chk("burst_wdata",   bus.burst_wdata,   e_wd);
    chk("pmem_resp",     bus.pmem_resp,     m_done);
    chk("pmem_rdata",    bus.pmem_rdata,    m_rdata);
  endtask

  task automatic cyc();
    @(posedge clk);
    if (!rst) model_step();
    @(negedge clk);
    check_cycle();
  endtask

  // Issues one request and plays the memory side. pat supplies burst_resp
  // bit by bit from cycle 1 (pat[0] first); past plen the memory answers
  // every cycle. Returns the cycle (counted from the request edge) in which
  // pmem_resp was seen.
  task automatic run_txn(input bit wr, input bit rd, input logic [31:0] a,
                         input logic [255:0] wl, input logic [255:0] rl,
                         input logic [15:0] pat, input int plen, input bit hold_rd,
                         output int resp_cyc);
    int c;
    int pi;
    c = 0;
    pi = 0;
    resp_cyc = -1;
    wq.delete();
    t_saw_read = 1'b0;
    bus.pmem_write   = wr;
    bus.pmem_read    = rd;
    bus.pmem_address = a;
    bus.pmem_wdata   = wl;
    bus.burst_resp   = 1'b0;
    bus.burst_rdata  = '0;
    while (resp_cyc < 0 && c < 40) begin
      cyc();
      c++;
      if (c == 1) begin
        t_first_addr = bus.burst_address;
        t_first_rd   = bus.burst_read;
        t_first_wr   = bus.burst_write;
      end
      if (bus.burst_read) t_saw_read = 1'b1;
      if (bus.pmem_resp) begin
        resp_cyc = c;
      end else begin
        bus.burst_resp  = (pi < plen) ? pat[pi] : 1'b1;
        pi++;
        bus.burst_rdata = rl[64*(m_beats % 4) +: 64];
        if (bus.burst_resp && bus.burst_write) wq.push_back(bus.burst_wdata);
      end
    end
    chk("txn_completes", resp_cyc >= 0, 1'b1);
    bus.pmem_write = 1'b0;
    bus.pmem_read  = hold_rd;
    bus.burst_resp = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rc;
    int cnt;

    rst              = 1'b1;
    bus.pmem_read    = 1'b0;
    bus.pmem_write   = 1'b0;
    bus.pmem_address = '0;
    bus.pmem_wdata   = '0;
    bus.burst_rdata  = '0;
    bus.burst_resp   = 1'b0;
    model_reset();
    cyc();
    cyc();
    chk("reset_pmem_resp",     bus.pmem_resp,     1'b0);
    chk("reset_pmem_rdata",    bus.pmem_rdata,    256'd0);
    chk("reset_burst_address", bus.burst_address, 32'd0);
    chk("reset_burst_wdata",   bus.burst_wdata,   64'd0);
    rst = 1'b0;
    cyc();

    // Zero-wait line fill.
    run_txn(1'b0, 1'b1, 32'h0000_1234, 256'd0, A_LINE, 16'h000F, 4, 1'b0, rc);
    $display("txn fill      addr=%h resp_cycle=%0d", t_first_addr, rc);
    chk("fill_resp_cycle", rc, 5);
    chk("fill_address",    t_first_addr, 32'h0000_1220);
    chk("fill_burst_read", t_first_rd, 1'b1);
    chk("fill_rdata",      bus.pmem_rdata, A_LINE);
    cyc();
    chk("fill_resp_one_cycle", bus.pmem_resp, 1'b0);

    // Writeback: beats in order, fill line untouched.
    run_txn(1'b1, 1'b0, 32'h0000_805F, L_LINE, 256'd0, 16'h000F, 4, 1'b0, rc);
    $display("txn writeback addr=%h resp_cycle=%0d beats=%0d", t_first_addr, rc, wq.size());
    chk("wb_resp_cycle", rc, 5);
    chk("wb_address",    t_first_addr, 32'h0000_8040);
    chk("wb_beats",      wq.size(), 4);
    if (wq.size() == 4) begin
      chk("wb_beat0", wq[0], 64'hAAAA_0000_1111_1111);
      chk("wb_beat1", wq[1], 64'hBBBB_0000_1111_2222);
      chk("wb_beat2", wq[2], 64'hCCCC_0000_1111_3333);
      chk("wb_beat3", wq[3], 64'hDDDD_0000_1111_4444);
    end
    chk("wb_no_read",    t_saw_read, 1'b0);
    chk("wb_rdata_kept", bus.pmem_rdata, A_LINE);
    cyc();

    // Fill with wait states: 1,0,0,1,1,0,1 -> three extra cycles.
    run_txn(1'b0, 1'b1, 32'h0000_2000, 256'd0, B_LINE, 16'h0059, 7, 1'b0, rc);
    $display("txn waitfill  addr=%h resp_cycle=%0d", t_first_addr, rc);
    chk("wait_resp_cycle", rc, 8);
    chk("wait_rdata",      bus.pmem_rdata, B_LINE);
    cyc();

    // Simultaneous read+write: write first, then the still-held read.
    run_txn(1'b1, 1'b1, 32'h0000_3000, L_LINE, 256'd0, 16'h000F, 4, 1'b1, rc);
    $display("txn both-wr   addr=%h resp_cycle=%0d", t_first_addr, rc);
    chk("both_write_first", t_first_wr, 1'b1);
    chk("both_no_read",     t_saw_read, 1'b0);
    chk("both_wr_resp",     rc, 5);
    run_txn(1'b0, 1'b1, 32'h0000_4000, 256'd0, C_LINE, 16'h000F, 4, 1'b0, rc);
    $display("txn both-rd   resp_cycle=%0d", rc);
    chk("both_rd_resp",  rc, 6);
    chk("both_rd_rdata", bus.pmem_rdata, C_LINE);
    cyc();

    // Reset after two read beats.
    bus.pmem_read    = 1'b1;
    bus.pmem_address = 32'h0000_5010;
    cyc();
    bus.burst_resp  = 1'b1;
    bus.burst_rdata = 64'hDEAD_0000_0000_0000;
    cyc();
    bus.burst_rdata = 64'hDEAD_0000_0000_0001;
    cyc();
    bus.burst_resp = 1'b0;
    bus.pmem_read  = 1'b0;
    rst = 1'b1;
    model_reset();
    #1;
    chk("rst_mid_rdata",   bus.pmem_rdata,    256'd0);
    chk("rst_mid_rd",      bus.burst_read,    1'b0);
    chk("rst_mid_address", bus.burst_address, 32'd0);
    chk("rst_mid_resp",    bus.pmem_resp,     1'b0);
    chk("rst_mid_wdata",   bus.burst_wdata,   64'd0);
    cyc();
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (bus.pmem_resp) cnt++;
    end
    chk("rst_no_resp", cnt, 0);
    run_txn(1'b0, 1'b1, 32'h0000_5010, 256'd0, E_LINE, 16'h000F, 4, 1'b0, rc);
    $display("txn post-rst  addr=%h resp_cycle=%0d", t_first_addr, rc);
    chk("rst_refill_resp",  rc, 5);
    chk("rst_refill_rdata", bus.pmem_rdata, E_LINE);
    cyc();

    // Stray responses while idle.
    bus.burst_resp  = 1'b1;
    bus.burst_rdata = 64'h5757_5757_5757_5757;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (bus.pmem_resp || bus.burst_read || bus.burst_write) cnt++;
    end
    chk("stray_no_activity", cnt, 0);
    chk("stray_rdata",       bus.pmem_rdata, E_LINE);
    run_txn(1'b0, 1'b1, 32'h0000_6000, 256'd0, F_LINE, 16'h000F, 4, 1'b0, rc);
    $display("txn post-stray addr=%h resp_cycle=%0d", t_first_addr, rc);
    chk("stray_then_resp",  rc, 5);
    chk("stray_then_rdata", bus.pmem_rdata, F_LINE);
    cyc();

    // Randomized traffic: requests toggle freely (ignored while busy),
    // memory answers about 60% of cycles, occasional asynchronous reset.
    for (int i = 0; i < 3000; i++) begin
      if (rst) begin
        rst = 1'b0;
      end else if ($urandom_range(0, 299) == 0) begin
        rst = 1'b1;
        model_reset();
      end
      bus.pmem_read    = ($urandom_range(0, 3) == 0);
      bus.pmem_write   = ($urandom_range(0, 4) == 0);
      bus.pmem_address = $urandom;
      bus.pmem_wdata   = {$urandom, $urandom, $urandom, $urandom,
                          $urandom, $urandom, $urandom, $urandom};
      bus.burst_resp   = ($urandom_range(0, 9) < 6);
      bus.burst_rdata  = {$urandom, $urandom};
      cyc();
      if (bus.pmem_resp) $display("txn random done cycle=%0d rdata=%h", i, bus.pmem_rdata[63:0]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
